// File: rtl/incrementor.sv
// N-bit unsigned +1 incrementor built from a half-adder chain, with an optional
// registered copy of the result plus carry, valid pulse and saturating wrap count.
module incrementor #(
   parameter int unsigned N      = 4,
   parameter int unsigned WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      in,
   input  logic              en,
   output logic [N-1:0]      out,
   output logic              carry,
   output logic [N-1:0]      q,
   output logic              q_carry,
   output logic              q_valid,
   output logic [WRAP_W-1:0] wrap_cnt
);

   localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

   logic [N-1:0]      q_d, q_q;
   logic              q_carry_d, q_carry_q;
   logic              q_valid_d, q_valid_q;
   logic [WRAP_W-1:0] wrap_cnt_d, wrap_cnt_q;

   // Ripple half-adder chain seeded with a constant carry-in of 1
   always_comb begin
      logic c;
      c   = 1'b1;
      out = '0;
      for (int unsigned i = 0; i < N; i++) begin
         out[i] = in[i] ^ c;
         c      = in[i] & c;
      end
      carry = c;
   end

   // Capture on en; valid drops whenever en is low
   always_comb begin
      q_d        = q_q;
      q_carry_d  = q_carry_q;
      q_valid_d  = 1'b0;
      wrap_cnt_d = wrap_cnt_q;
      if (en) begin
         q_d       = out;
         q_carry_d = carry;
         q_valid_d = 1'b1;
         if (carry && (wrap_cnt_q != WRAP_MAX)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q        <= '0;
         q_carry_q  <= 1'b0;
         q_valid_q  <= 1'b0;
         wrap_cnt_q <= '0;
      end else begin
         q_q        <= q_d;
         q_carry_q  <= q_carry_d;
         q_valid_q  <= q_valid_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign q        = q_q;
   assign q_carry  = q_carry_q;
   assign q_valid  = q_valid_q;
   assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_incrementor.sv
// Directed self-checking bench for incrementor at N=4, N=1, N=8 and a
// narrow-counter N=4/WRAP_W=2 instance sharing one clock and reset.
module tb_incrementor;

   logic clk;
   logic rst_n;

   logic [3:0] in4, out4, q4;
   logic       en4, carry4, q_carry4, q_valid4;
   logic [7:0] wrap4;

   logic [0:0] in1, out1, q1;
   logic       en1, carry1, q_carry1, q_valid1;
   logic [7:0] wrap1;

   logic [7:0] in8, out8, q8;
   logic       en8, carry8, q_carry8, q_valid8;
   logic [7:0] wrap8;

   logic [3:0] inw, outw, qw;
   logic       enw, carryw, q_carryw, q_validw;
   logic [1:0] wrapw;

   int n_cmp;
   int n_err;

   incrementor #(.N(4), .WRAP_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in(in4), .en(en4), .out(out4), .carry(carry4),
      .q(q4), .q_carry(q_carry4), .q_valid(q_valid4), .wrap_cnt(wrap4));

   incrementor #(.N(1), .WRAP_W(8)) dut_n1 (
      .clk(clk), .rst_n(rst_n), .in(in1), .en(en1), .out(out1), .carry(carry1),
      .q(q1), .q_carry(q_carry1), .q_valid(q_valid1), .wrap_cnt(wrap1));

   incrementor #(.N(8), .WRAP_W(8)) dut_n8 (
      .clk(clk), .rst_n(rst_n), .in(in8), .en(en8), .out(out8), .carry(carry8),
      .q(q8), .q_carry(q_carry8), .q_valid(q_valid8), .wrap_cnt(wrap8));

   incrementor #(.N(4), .WRAP_W(2)) dut_w2 (
      .clk(clk), .rst_n(rst_n), .in(inw), .en(enw), .out(outw), .carry(carryw),
      .q(qw), .q_carry(q_carryw), .q_valid(q_validw), .wrap_cnt(wrapw));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [3:0] sweep_in  [5] = '{4'd0, 4'd1, 4'd7, 4'd14, 4'd15};
   logic [3:0] sweep_out [5] = '{4'd1, 4'd2, 4'd8, 4'd15, 4'd0};
   logic       sweep_cy  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      in4 = '0; en4 = 1'b0;
      in1 = '0; en1 = 1'b0;
      in8 = '0; en8 = 1'b0;
      inw = '0; enw = 1'b0;

      // Asynchronous reset state before any clock edge
      #1;
      check("rst_q",        32'(q4),       32'd0);
      check("rst_q_carry",  32'(q_carry4), 32'd0);
      check("rst_q_valid",  32'(q_valid4), 32'd0);
      check("rst_wrap",     32'(wrap4),    32'd0);
      check("rst_n1_regs",  32'({q1, q_carry1, q_valid1, wrap1}), 32'd0);
      check("rst_n8_regs",  32'({q8, q_carry8, q_valid8, wrap8}), 32'd0);
      check("rst_w2_regs",  32'({qw, q_carryw, q_validw, wrapw}), 32'd0);

      // Directed combinational sweep, outputs track in during reset
      for (int i = 0; i < 5; i++) begin
         in4 = sweep_in[i];
         #10;
         check($sformatf("sweep_out[%0d]", sweep_in[i]),   32'(out4),   32'(sweep_out[i]));
         check($sformatf("sweep_carry[%0d]", sweep_in[i]), 32'(carry4), 32'(sweep_cy[i]));
      end

      // Exhaustive N=4
      for (int i = 0; i < 16; i++) begin
         in4 = 4'(i);
         #10;
         check($sformatf("exh_out[%0d]", i),   32'(out4),   32'((i + 1) % 16));
         check($sformatf("exh_carry[%0d]", i), 32'(carry4), (i == 15) ? 32'd1 : 32'd0);
      end

      // N=1 and N=8 boundaries
      in1 = 1'b0; #10;
      check("n1_out_0",   32'(out1),   32'd1);
      check("n1_carry_0", 32'(carry1), 32'd0);
      in1 = 1'b1; #10;
      check("n1_out_1",   32'(out1),   32'd0);
      check("n1_carry_1", 32'(carry1), 32'd1);
      in8 = 8'd255; #10;
      check("n8_out_255",   32'(out8),   32'd0);
      check("n8_carry_255", 32'(carry8), 32'd1);
      in8 = 8'd127; #10;
      check("n8_out_127",   32'(out8),   32'd128);
      check("n8_carry_127", 32'(carry8), 32'd0);

      // Single-cycle capture of in=5
      @(negedge clk);
      rst_n = 1'b1;
      in4 = 4'd5; en4 = 1'b1;
      @(negedge clk);
      en4 = 1'b0;
      check("cap_q",       32'(q4),       32'd6);
      check("cap_q_carry", 32'(q_carry4), 32'd0);
      check("cap_q_valid", 32'(q_valid4), 32'd1);
      check("cap_wrap",    32'(wrap4),    32'd0);
      @(negedge clk);
      check("cap_valid_drop", 32'(q_valid4), 32'd0);
      check("cap_q_hold",     32'(q4),       32'd6);

      // Three back-to-back wraps
      in4 = 4'd15; en4 = 1'b1;
      @(negedge clk);
      check("wrap_valid_1", 32'(q_valid4), 32'd1);
      @(negedge clk);
      check("wrap_valid_2", 32'(q_valid4), 32'd1);
      @(negedge clk);
      en4 = 1'b0;
      check("wrap_cnt_3",   32'(wrap4),    32'd3);
      check("wrap_q",       32'(q4),       32'd0);
      check("wrap_q_carry", 32'(q_carry4), 32'd1);

      // Narrow counter saturates at 3 after 5 wraps
      inw = 4'd15; enw = 1'b1;
      repeat (5) @(negedge clk);
      enw = 1'b0;
      check("w2_sat",  32'(wrapw), 32'd3);
      check("w2_q",    32'(qw),    32'd0);
      @(negedge clk);
      check("w2_sat_hold", 32'(wrapw), 32'd3);

      // Build q=6, wrap_cnt=2 then reset between edges
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      check("rerst_wrap", 32'(wrap4), 32'd0);
      @(negedge clk);
      in4 = 4'd15; en4 = 1'b1;
      repeat (2) @(negedge clk);
      in4 = 4'd5;
      @(negedge clk);
      en4 = 1'b0;
      check("pre_rst_q",    32'(q4),    32'd6);
      check("pre_rst_wrap", 32'(wrap4), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_q",       32'(q4),       32'd0);
      check("async_q_carry", 32'(q_carry4), 32'd0);
      check("async_q_valid", 32'(q_valid4), 32'd0);
      check("async_wrap",    32'(wrap4),    32'd0);
      check("async_out",     32'(out4),     32'd6);
      check("async_carry",   32'(carry4),   32'd0);

      // en low: registered state holds while out follows in
      @(negedge clk);
      rst_n = 1'b1;
      in4 = 4'd15; en4 = 1'b1;
      @(negedge clk);
      en4 = 1'b0;
      in4 = 4'd3;
      repeat (2) @(negedge clk);
      check("hold_q",       32'(q4),       32'd0);
      check("hold_q_carry", 32'(q_carry4), 32'd1);
      check("hold_wrap",    32'(wrap4),    32'd1);
      check("hold_q_valid", 32'(q_valid4), 32'd0);
      check("hold_out",     32'(out4),     32'd4);
      in4 = 4'd9;
      @(negedge clk);
      check("hold_q_2",  32'(q4),   32'd0);
      check("hold_out_2", 32'(out4), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
